stq_adata_mp: RTL and testbench
===============================

// Module: stq_adata_mp
// PURPOSE
//  Parametrised multi-port side table for store-queue per-entry address metadata (bank/size/alias bits).
//  Indexed by store-queue slot (WQ).
//  Generalises the fixed 64x5, 2W/2R table:
//  - any width, depth and port counts;
//  - per-entry valid bits, single-entry invalidate, full flush;
//  - registered reads with same-cycle write bypass;
//  - live-entry counter.
//  Sits beside the store-queue data array. Written at store dispatch, read at address update and retire.
// PARAMETERS
//  WIDTH   5   metadata bits per entry
//  DEPTH   64  entries; power of two, >=2
//  AW      6   index width = log2(DEPTH)
//  NWR     2   write ports, 1..4
//  NRD     2   read ports, 1..4
//  BYPASS  1   1: a same-cycle write is forwarded to a read of the same index. 0: the read returns the old value.
// PORTS
//  clk        in   1           clock, rising edge
//  rst        in   1           asynchronous, active-low reset
//  wrt_en     in   NWR         per-port write enable
//  wrt_WQ     in   NWR*AW      per-port index; port p = bits [p*AW +: AW]
//  wrt_adata  in   NWR*WIDTH   per-port write data
//  inv_en     in   1           invalidate one entry
//  inv_WQ     in   AW          index to invalidate
//  flush      in   1           clear all valid bits
//  upd_WQ     in   NRD*AW      per-port read index
//  upd_adata  out  NRD*WIDTH   registered read data
//  upd_vld    out  NRD         registered valid bit of the entry read
//  live_cnt   out  AW+1        registered count of valid entries, 0..DEPTH
// BEHAVIOUR
//  Reset (rst low, async):
//  - all data entries = 0, all valid bits = 0;
//  - upd_adata = 0, upd_vld = 0, live_cnt = 0.
//  Reset deasserting mid-operation: the first edge after release behaves as a normal cycle.
//  Write, at rising edge: if wrt_en[p], then data[wrt_WQ[p]] <= wrt_adata[p] and valid[wrt_WQ[p]] <= 1.
//  - Two or more ports writing the same index in one cycle: the lowest port number wins.
//  - Invalidate: if inv_en, valid[inv_WQ] <= 0; data is kept. A write to the same index in the same cycle wins (valid=1, new data).
//  - Flush: all valid <= 0 next edge; overrides writes and inv in the same cycle; data array is still written.
//  Read, latency 1:
//  - index sampled at edge N; upd_adata/upd_vld are valid after edge N.
//  - The value is the pre-edge array content, unless BYPASS=1 and a write port targets the same index that cycle. Then it is that port's data with vld=1, using the same lowest-port priority.
//  - If flush is asserted in the same cycle, upd_vld = 0 even with bypass; data is still forwarded.
//  - An invalidate in the same cycle does not affect the read: the old valid is returned unless a bypass write hits.
//  live_cnt: registered popcount of the next-state valid vector, so it tracks the valid array with zero skew.
//  - Range 0..DEPTH; DEPTH is reachable, hence AW+1 bits; it cannot wrap.
//  Reads are unconditional every cycle; there is no read enable and no handshake or stall.
//  Out-of-range indices cannot occur: DEPTH = 2^AW.
// TESTING
//  1. Reset: pulse rst low between edges -> outputs 0 immediately, before any edge; reading every index returns adata=0, vld=0; live_cnt=0.
//  2. Write idx 5 = 5'h1A on port0, read idx 5 next cycle -> one cycle later upd_adata=5'h1A, upd_vld=1; live_cnt=1.
//  3. Collision: port0 writes idx 9 = 5'h03, port1 writes idx 9 = 5'h1F in the same cycle -> read returns 5'h03; live_cnt increments by 1, not 2.
//  4. Bypass: write idx 12 = 5'h0C and read idx 12 in the same cycle.
//     - BYPASS=1 -> 5'h0C, vld=1.
//     - BYPASS=0 -> old content.
//     - Repeat with flush asserted -> vld=0.
//  5. Invalidate vs write: fill idx 0..63 -> live_cnt=64.
//     - inv idx 7 alone -> 63, and a read of idx 7 gives vld=0 with data unchanged.
//     - inv idx 8 plus write idx 8 in the same cycle -> stays valid, count unchanged.
//  6. Flush: flush with two concurrent writes -> all vld=0 and live_cnt=0 next cycle; data from those writes is readable later with vld=0. Re-run with NWR=4, NRD=3, WIDTH=9, DEPTH=16.

Source files
------------

// File: rtl/stq_adata_mp_if.sv
// Port bundle for the store-queue address-metadata side table.
// Write, invalidate, flush and read ports are flattened per port, with port p at [p*W +: W].
interface stq_adata_mp_if #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned AW    = 6,
    parameter int unsigned NWR   = 2,
    parameter int unsigned NRD   = 2
);
    logic [NWR-1:0]       wrt_en;
    logic [NWR*AW-1:0]    wrt_WQ;
    logic [NWR*WIDTH-1:0] wrt_adata;
    logic                 inv_en;
    logic [AW-1:0]        inv_WQ;
    logic                 flush;
    logic [NRD*AW-1:0]    upd_WQ;
    logic [NRD*WIDTH-1:0] upd_adata;
    logic [NRD-1:0]       upd_vld;
    logic [AW:0]          live_cnt;

    modport master (
        output wrt_en, wrt_WQ, wrt_adata, inv_en, inv_WQ, flush, upd_WQ,
        input  upd_adata, upd_vld, live_cnt
    );

    modport slave (
        input  wrt_en, wrt_WQ, wrt_adata, inv_en, inv_WQ, flush, upd_WQ,
        output upd_adata, upd_vld, live_cnt
    );
endinterface

// File: rtl/stq_adata_mp.sv
// Multi-port per-entry metadata table for the store queue, indexed by slot.
// Entries carry valid bits; reads are registered, with optional same-cycle write forwarding.
module stq_adata_mp #(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned AW     = 6,
    parameter int unsigned NWR    = 2,
    parameter int unsigned NRD    = 2,
    parameter bit          BYPASS = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    stq_adata_mp_if.slave  bus
);

    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_nxt_c;
    logic [CW-1:0]    cnt_nxt_c;
    logic [WIDTH-1:0] rd_data_c [NRD];
    logic [NRD-1:0]   rd_vld_c;

    // Data array; ports are applied highest first so the lowest port's write lands last
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int p = NWR - 1; p >= 0; p--) begin
                if (bus.wrt_en[p]) begin
                    mem[bus.wrt_WQ[p*AW +: AW]] <= bus.wrt_adata[p*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Next valid vector: writes beat invalidate, flush beats everything
    always_comb begin
        vld_nxt_c = vld_q;
        if (bus.inv_en) begin
            vld_nxt_c[bus.inv_WQ] = 1'b0;
        end
        for (int p = 0; p < NWR; p++) begin
            if (bus.wrt_en[p]) begin
                vld_nxt_c[bus.wrt_WQ[p*AW +: AW]] = 1'b1;
            end
        end
        if (bus.flush) begin
            vld_nxt_c = '0;
        end
    end

    always_comb begin
        cnt_nxt_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_nxt_c = cnt_nxt_c + CW'(vld_nxt_c[i]);
        end
    end

    // Read mux with optional forwarding from a write to the same slot
    always_comb begin
        rd_data_c = '{default: '0};
        rd_vld_c  = '0;
        for (int r = 0; r < NRD; r++) begin
            rd_data_c[r] = mem[bus.upd_WQ[r*AW +: AW]];
            rd_vld_c[r]  = vld_q[bus.upd_WQ[r*AW +: AW]];
            if (BYPASS) begin
                for (int p = NWR - 1; p >= 0; p--) begin
                    if (bus.wrt_en[p] && (bus.wrt_WQ[p*AW +: AW] == bus.upd_WQ[r*AW +: AW])) begin
                        rd_data_c[r] = bus.wrt_adata[p*WIDTH +: WIDTH];
                        rd_vld_c[r]  = 1'b1;
                    end
                end
            end
            if (bus.flush) begin
                rd_vld_c[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q         <= '0;
            bus.upd_adata <= '0;
            bus.upd_vld   <= '0;
            bus.live_cnt  <= '0;
        end else begin
            vld_q        <= vld_nxt_c;
            bus.live_cnt <= cnt_nxt_c;
            bus.upd_vld  <= rd_vld_c;
            for (int r = 0; r < NRD; r++) begin
                bus.upd_adata[r*WIDTH +: WIDTH] <= rd_data_c[r];
            end
        end
    end

endmodule

// File: tb/tb_stq_adata_mp.sv
// Scoreboard bench for stq_adata_mp: default bypassing table, a non-bypassing twin
// sharing its inputs, and a 4W/3R 9x16 variant.
module tb_stq_adata_mp;

    logic clk;
    logic rst;

    stq_adata_mp_if #(.WIDTH(5), .AW(6), .NWR(2), .NRD(2)) ia ();
    stq_adata_mp_if #(.WIDTH(9), .AW(4), .NWR(4), .NRD(3)) ib ();
    stq_adata_mp_if #(.WIDTH(5), .AW(6), .NWR(2), .NRD(2)) ic ();

    stq_adata_mp #(.WIDTH(5), .DEPTH(64), .AW(6), .NWR(2), .NRD(2), .BYPASS(1'b1))
        u_a (.clk(clk), .rst(rst), .bus(ia.slave));
    stq_adata_mp #(.WIDTH(9), .DEPTH(16), .AW(4), .NWR(4), .NRD(3), .BYPASS(1'b1))
        u_b (.clk(clk), .rst(rst), .bus(ib.slave));
    stq_adata_mp #(.WIDTH(5), .DEPTH(64), .AW(6), .NWR(2), .NRD(2), .BYPASS(1'b0))
        u_c (.clk(clk), .rst(rst), .bus(ic.slave));

    assign ic.wrt_en    = ia.wrt_en;
    assign ic.wrt_WQ    = ia.wrt_WQ;
    assign ic.wrt_adata = ia.wrt_adata;
    assign ic.inv_en    = ia.inv_en;
    assign ic.inv_WQ    = ia.inv_WQ;
    assign ic.flush     = ia.flush;
    assign ic.upd_WQ    = ia.upd_WQ;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        int         dut;
        int         port;
        logic [8:0] d;
        logic       v;
        logic [6:0] c;
    } exp_t;

    exp_t sq[$];
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic exp_rd(input int dut, input int port, input logic [8:0] d, input logic v);
        exp_t e;
        e.cyc = cyc + 1; e.dut = dut; e.port = port; e.d = d; e.v = v; e.c = '0;
        sq.push_back(e);
    endtask

    task automatic exp_cnt(input int dut, input logic [6:0] c);
        exp_t e;
        e.cyc = cyc + 1; e.dut = dut; e.port = -1; e.d = '0; e.v = 1'b0; e.c = c;
        sq.push_back(e);
    endtask

    // Monitor: outputs update every edge; compare everything due at this edge
    initial begin
        exp_t e;
        int ad, av, ac;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (sq.size() > 0 && sq[0].cyc <= cyc) begin
                e = sq.pop_front();
                ad = 0; av = 0; ac = 0;
                if (e.dut == 0) begin
                    ac = int'(ia.live_cnt);
                    if (e.port >= 0) begin
                        ad = int'(ia.upd_adata[e.port*5 +: 5]);
                        av = int'(ia.upd_vld[e.port]);
                    end
                end else if (e.dut == 1) begin
                    ac = int'(ib.live_cnt);
                    if (e.port >= 0) begin
                        ad = int'(ib.upd_adata[e.port*9 +: 9]);
                        av = int'(ib.upd_vld[e.port]);
                    end
                end else begin
                    ac = int'(ic.live_cnt);
                    if (e.port >= 0) begin
                        ad = int'(ic.upd_adata[e.port*5 +: 5]);
                        av = int'(ic.upd_vld[e.port]);
                    end
                end
                if (e.port < 0) begin
                    chk($sformatf("live_cnt dut%0d cyc%0d", e.dut, e.cyc), ac, int'(e.c));
                end else begin
                    chk($sformatf("adata dut%0d port%0d cyc%0d", e.dut, e.port, e.cyc), ad, int'(e.d));
                    chk($sformatf("vld dut%0d port%0d cyc%0d", e.dut, e.port, e.cyc), av, int'(e.v));
                end
            end
        end
    end

    task automatic a_idle();
        ia.wrt_en = '0; ia.inv_en = 1'b0; ia.flush = 1'b0;
    endtask

    task automatic b_idle();
        ib.wrt_en = '0; ib.inv_en = 1'b0; ib.flush = 1'b0;
    endtask

    task automatic a_wr(input int p, input int idx, input int d);
        ia.wrt_en[p] = 1'b1;
        ia.wrt_WQ[p*6 +: 6] = 6'(idx);
        ia.wrt_adata[p*5 +: 5] = 5'(d);
    endtask

    task automatic a_rd(input int r, input int idx);
        ia.upd_WQ[r*6 +: 6] = 6'(idx);
    endtask

    task automatic b_wr(input int p, input int idx, input int d);
        ib.wrt_en[p] = 1'b1;
        ib.wrt_WQ[p*4 +: 4] = 4'(idx);
        ib.wrt_adata[p*9 +: 9] = 9'(d);
    endtask

    task automatic b_rd(input int r, input int idx);
        ib.upd_WQ[r*4 +: 4] = 4'(idx);
    endtask

    task automatic step();
        @(negedge clk);
        a_idle();
        b_idle();
    endtask

    initial begin
        rst = 1'b1;
        a_idle(); b_idle();
        ia.wrt_WQ = '0; ia.wrt_adata = '0; ia.inv_WQ = '0; ia.upd_WQ = '0;
        ib.wrt_WQ = '0; ib.wrt_adata = '0; ib.inv_WQ = '0; ib.upd_WQ = '0;

        // Reset asserted before the first edge must clear outputs at once
        #1 rst = 1'b0;
        #2;
        chk("rst0 a adata", int'(ia.upd_adata), 0);
        chk("rst0 a vld", int'(ia.upd_vld), 0);
        chk("rst0 a cnt", int'(ia.live_cnt), 0);
        chk("rst0 b cnt", int'(ib.live_cnt), 0);
        #5 rst = 1'b1;

        // Every slot reads back empty
        for (int i = 0; i < 32; i++) begin
            step();
            a_rd(0, 2*i); a_rd(1, 2*i + 1);
            exp_rd(0, 0, 9'h0, 1'b0); exp_rd(0, 1, 9'h0, 1'b0); exp_cnt(0, 7'd0);
        end

        // Simple write then read
        step(); a_wr(0, 5, 'h1A); exp_cnt(0, 7'd1);
        step(); a_rd(0, 5);
        exp_rd(0, 0, 9'h1A, 1'b1); exp_rd(2, 0, 9'h1A, 1'b1); exp_cnt(0, 7'd1);

        // Same-slot collision: port0 wins, counted once
        step(); a_wr(0, 9, 'h03); a_wr(1, 9, 'h1F); exp_cnt(0, 7'd2); exp_cnt(2, 7'd2);
        step(); a_rd(0, 9);
        exp_rd(0, 0, 9'h03, 1'b1); exp_rd(2, 0, 9'h03, 1'b1); exp_cnt(0, 7'd2);

        // Bypass vs. no bypass, then with flush
        step(); a_wr(0, 12, 'h0C); a_rd(0, 12);
        exp_rd(0, 0, 9'h0C, 1'b1); exp_rd(2, 0, 9'h00, 1'b0); exp_cnt(0, 7'd3);
        step();
        exp_rd(0, 0, 9'h0C, 1'b1); exp_rd(2, 0, 9'h0C, 1'b1);
        step(); a_wr(0, 12, 'h15); ia.flush = 1'b1;
        exp_rd(0, 0, 9'h15, 1'b0); exp_rd(2, 0, 9'h0C, 1'b0); exp_cnt(0, 7'd0); exp_cnt(2, 7'd0);
        step();
        exp_rd(0, 0, 9'h15, 1'b0); exp_rd(2, 0, 9'h15, 1'b0); exp_cnt(0, 7'd0);

        // Fill all 64 slots with idx ^ 0x15
        for (int i = 0; i < 32; i++) begin
            step();
            a_wr(0, 2*i, (2*i) ^ 'h15); a_wr(1, 2*i + 1, (2*i + 1) ^ 'h15);
            exp_cnt(0, 7'(2*(i + 1)));
        end
        exp_cnt(2, 7'd64);

        step(); ia.inv_en = 1'b1; ia.inv_WQ = 6'd7; exp_cnt(0, 7'd63); exp_cnt(2, 7'd63);
        step(); a_rd(0, 7); a_rd(1, 6);
        exp_rd(0, 0, 9'h12, 1'b0); exp_rd(0, 1, 9'h13, 1'b1); exp_rd(2, 0, 9'h12, 1'b0);

        // Invalidate and write to the same slot: write wins
        step(); ia.inv_en = 1'b1; ia.inv_WQ = 6'd8; a_wr(1, 8, 'h0A); a_rd(0, 8);
        exp_rd(0, 0, 9'h0A, 1'b1); exp_rd(2, 0, 9'h1D, 1'b1); exp_cnt(0, 7'd63); exp_cnt(2, 7'd63);
        step();
        exp_rd(0, 0, 9'h0A, 1'b1); exp_rd(2, 0, 9'h0A, 1'b1); exp_cnt(0, 7'd63);

        // Flush with two concurrent writes
        step(); ia.flush = 1'b1; a_wr(0, 20, 'h01); a_wr(1, 21, 'h02);
        exp_rd(0, 0, 9'h0A, 1'b0); exp_cnt(0, 7'd0); exp_cnt(2, 7'd0);
        step(); a_rd(0, 20); a_rd(1, 21);
        exp_rd(0, 0, 9'h01, 1'b0); exp_rd(0, 1, 9'h02, 1'b0); exp_cnt(0, 7'd0);
        step(); a_rd(0, 7);
        exp_rd(0, 0, 9'h12, 1'b0); exp_rd(2, 0, 9'h12, 1'b0);

        // Wide variant: priority, bypass, flush, fill to DEPTH, invalidate
        step(); b_wr(0, 3, 'h1A5); b_wr(2, 3, 'h0FF); b_wr(3, 15, 'h100);
        b_rd(0, 3); b_rd(1, 15); b_rd(2, 0);
        exp_rd(1, 0, 9'h1A5, 1'b1); exp_rd(1, 1, 9'h100, 1'b1); exp_rd(1, 2, 9'h000, 1'b0);
        exp_cnt(1, 7'd2);
        step(); ib.flush = 1'b1; b_wr(1, 4, 'h055); b_wr(3, 5, 'h0AA);
        exp_rd(1, 0, 9'h1A5, 1'b0); exp_rd(1, 1, 9'h100, 1'b0); exp_cnt(1, 7'd0);
        step(); b_rd(0, 4); b_rd(1, 5); b_rd(2, 3);
        exp_rd(1, 0, 9'h055, 1'b0); exp_rd(1, 1, 9'h0AA, 1'b0); exp_rd(1, 2, 9'h1A5, 1'b0);
        exp_cnt(1, 7'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            for (int p = 0; p < 4; p++) b_wr(p, 4*i + p, (4*i + p) * 17);
            exp_cnt(1, 7'(4*(i + 1)));
        end
        step(); b_rd(0, 15); b_rd(1, 0); b_rd(2, 7);
        exp_rd(1, 0, 9'h0FF, 1'b1); exp_rd(1, 1, 9'h000, 1'b1); exp_rd(1, 2, 9'h077, 1'b1);
        exp_cnt(1, 7'd16);
        step(); ib.inv_en = 1'b1; ib.inv_WQ = 4'd0;
        exp_rd(1, 1, 9'h000, 1'b1); exp_cnt(1, 7'd15);
        step();
        exp_rd(1, 1, 9'h000, 1'b0); exp_cnt(1, 7'd15);

        // Reset pulse mid-operation clears data as well as valids
        step(); a_wr(0, 3, 'h07); exp_cnt(0, 7'd1);
        step(); a_rd(0, 3); exp_rd(0, 0, 9'h07, 1'b1);
        step();
        #2 rst = 1'b0;
        #1;
        chk("rst1 a adata", int'(ia.upd_adata), 0);
        chk("rst1 a vld", int'(ia.upd_vld), 0);
        chk("rst1 a cnt", int'(ia.live_cnt), 0);
        chk("rst1 b cnt", int'(ib.live_cnt), 0);
        #1 rst = 1'b1;
        step(); a_rd(0, 3);
        exp_rd(0, 0, 9'h00, 1'b0); exp_rd(2, 0, 9'h00, 1'b0); exp_cnt(0, 7'd0);

        repeat (3) step();
        chk("scoreboard drained", sq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
